seq_mult_nbit: RTL and testbench

- Parametrised, iterative shift-add multiplier. Successor to the fixed 4-bit combinational array multiplier.
- Trades area for latency: one partial-product bit is retired per clock.
- Supports a configurable operand width, signed or unsigned operation selected per transaction, and a start/busy/done handshake.
- Sits in the arithmetic datapath and is driven by a controller that issues one multiply at a time.

---
 rtl/seq_mult_nbit_if.sv | 23 ++
 rtl/seq_mult_nbit.sv | 104 ++++++++++
 tb/tb_seq_mult_nbit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_nbit_if.sv
// Request/response bundle for the iterative multiplier: the controller drives the operands and
// start, and the multiplier returns busy, done and the product.
interface seq_mult_nbit_if #(
    parameter int unsigned N = 8
) ();
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/seq_mult_nbit.sv
// Iterative shift-add multiplier that retires one multiplier bit per clock. Signed operands are
// multiplied as magnitudes, and the sign is applied to the product when the operation finishes.
module seq_mult_nbit #(
    parameter int unsigned N = 8
) (
    input logic           clk,
    input logic           rst,
    seq_mult_nbit_if.slave bus
);
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e         state_q, state_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0]   mb_q, mb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   a_mag, b_mag;

    // The most negative value maps to 2^(N-1), which still fits in N unsigned bits.
    assign a_mag = (bus.signed_mode && bus.a[N-1]) ? -bus.a : bus.a;
    assign b_mag = (bus.signed_mode && bus.b[N-1]) ? -bus.b : bus.b;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        p_d     = p_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle, StFin: begin
                if (bus.start) begin
                    state_d = StCalc;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    mcand_d = {{N{1'b0}}, a_mag};
                    mb_d    = b_mag;
                    cnt_d   = '0;
                    neg_d   = bus.signed_mode & (bus.a[N-1] ^ bus.b[N-1]);
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            StCalc: begin
                // The counter reaches N after the last bit, leaving one cycle to apply the sign.
                if (cnt_q == CW'(N)) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    p_d     = neg_q ? -acc_q : acc_q;
                end else begin
                    if (mb_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    mb_d    = mb_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mcand_q <= '0;
            p_q     <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            p_q     <= p_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;
endmodule

// File: tb/tb_seq_mult_nbit.sv
// Bench for seq_mult_nbit at N=8 (directed), N=4 (exhaustive) and N=16 (random), with a queue of
// expected products per instance that is consumed on every done pulse.
module tb_seq_mult_nbit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_mult_nbit_if #(.N(8))  if8 ();
    seq_mult_nbit_if #(.N(4))  if4 ();
    seq_mult_nbit_if #(.N(16)) if16 ();

    seq_mult_nbit #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    seq_mult_nbit #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    seq_mult_nbit #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] q8[$], q4[$], q16[$];
    int acc8 = 0, acc4 = 0, acc16 = 0;
    int d8 = 0, d4 = 0, d16 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] gold(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic sm);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[5'(w-1)]) sa = sa - (longint'(1) << w);
        if (sm && b[5'(w-1)]) sb = sb - (longint'(1) << w);
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Scoreboards: every done pops the oldest expectation.
    always @(negedge clk) begin
        if (if8.done) begin
            d8++;
            check("done8 expected", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) check("p8", 64'(if8.p), q8.pop_front());
        end
        if (if4.done) begin
            d4++;
            check("done4 expected", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) check("p4", 64'(if4.p), q4.pop_front());
        end
        if (if16.done) begin
            d16++;
            check("done16 expected", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) check("p16", 64'(if16.p), q16.pop_front());
        end
    end

    // Called just after an accept edge; returns at the negedge where done is seen.
    task automatic wait8(output int cyc, output int bcnt, output int pchg);
        logic [15:0] p0;
        p0   = if8.p;
        cyc  = 0;
        bcnt = 0;
        pchg = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!if8.done) begin
                if (if8.busy) bcnt++;
                if (if8.p !== p0) pchg++;
            end
        end while (!if8.done && cyc < 40);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp, input string tag);
        int cyc, bcnt, pchg;
        if8.a = a; if8.b = b; if8.signed_mode = sm; if8.start = 1'b1;
        q8.push_back(64'(exp));
        acc8++;
        @(posedge clk);
        #1 if8.start = 1'b0;
        wait8(cyc, bcnt, pchg);
        check({tag, " latency"}, 64'(cyc), 64'd9);
        check({tag, " busy cycles"}, 64'(bcnt), 64'd8);
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        int k;
        if4.a = a; if4.b = b; if4.signed_mode = sm; if4.start = 1'b1;
        q4.push_back(gold(4, 32'(a), 32'(b), sm));
        acc4++;
        @(posedge clk);
        #1 if4.start = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!if4.done && k < 20);
        check("done4 seen", 64'(if4.done), 64'd1);
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        int k;
        if16.a = a; if16.b = b; if16.signed_mode = sm; if16.start = 1'b1;
        q16.push_back(gold(16, 32'(a), 32'(b), sm));
        acc16++;
        @(posedge clk);
        #1 if16.start = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!if16.done && k < 40);
        check("done16 seen", 64'(if16.done), 64'd1);
    endtask

    initial begin
        int cyc, bcnt, pchg;
        if8.start = 0;  if8.signed_mode = 0;  if8.a = '0;  if8.b = '0;
        if4.start = 0;  if4.signed_mode = 0;  if4.a = '0;  if4.b = '0;
        if16.start = 0; if16.signed_mode = 0; if16.a = '0; if16.b = '0;

        // Reset and quiet period
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(if8.busy), 64'd0);
        check("reset done", 64'(if8.done), 64'd0);
        check("reset p", 64'(if8.p), 64'h0000);
        repeat (20) @(negedge clk);
        check("no done while idle", 64'(d8), 64'd0);

        // Unsigned maximum and signed corners
        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u ff*ff");
        run8(8'h80, 8'h80, 1'b1, 16'h4000, "s 80*80");
        run8(8'h80, 8'h7F, 1'b1, 16'hC080, "s 80*7f");
        run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s -3*5");
        run8(8'h00, 8'h9C, 1'b1, 16'h0000, "s 0*9c");

        // Start during CALC is ignored; start in FIN is accepted back-to-back
        if8.a = 8'd3; if8.b = 8'd4; if8.signed_mode = 1'b0; if8.start = 1'b1;
        q8.push_back(64'd12);
        acc8++;
        @(posedge clk);
        #1 if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 begin if8.a = 8'd9; if8.b = 8'd9; if8.start = 1'b1; end
        @(posedge clk);
        #1 if8.start = 1'b0;
        wait8(cyc, bcnt, pchg);
        check("hs first done", 64'(if8.done), 64'd1);
        check("hs first p", 64'(if8.p), 64'd12);
        if8.a = 8'd10; if8.b = 8'd10; if8.signed_mode = 1'b0; if8.start = 1'b1;
        q8.push_back(64'd100);
        acc8++;
        @(posedge clk);
        #1 if8.start = 1'b0;
        check("hs busy after FIN accept", 64'(if8.busy), 64'd1);
        wait8(cyc, bcnt, pchg);
        check("hs b2b latency", 64'(cyc), 64'd9);
        check("hs p held until done", 64'(pchg), 64'd0);

        // Reset in the 4th CALC cycle aborts without done
        if8.a = 8'd200; if8.b = 8'd200; if8.start = 1'b1;
        @(posedge clk);
        #1 if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(if8.busy), 64'd0);
        check("abort done", 64'(if8.done), 64'd0);
        check("abort p", 64'(if8.p), 64'd0);
        repeat (15) @(negedge clk);
        check("abort no done", 64'(d8), 64'(acc8));
        run8(8'd2, 8'd3, 1'b0, 16'd6, "post-abort 2*3");

        // N=4 exhaustive, both modes
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    go4(4'(i), 4'(j), 1'(s));

        // N=16 corners then random
        go16(16'h8000, 16'h8000, 1'b1);
        go16(16'hFFFF, 16'hFFFF, 1'b0);
        go16(16'h8000, 16'h7FFF, 1'b1);
        for (int i = 0; i < 300; i++)
            go16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        repeat (5) @(negedge clk);
        check("done8 count", 64'(d8), 64'(acc8));
        check("done4 count", 64'(d4), 64'(acc4));
        check("done16 count", 64'(d16), 64'(acc16));
        check("queues drained", 64'(q8.size() + q4.size() + q16.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
